spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sck_gen.sv | 74 +++++++
 rtl/spi_master.sv | 150 +++++++++++++++
 tb/tb_spi_master.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master slice.
//   spi_state_t           : frame-level FSM states
//   SPI_CPOL / SPI_CPHA   : SPI mode-0 clock polarity and phase
//   HALF_PERIODS_PER_BYTE : SCK half-periods making up one byte
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    NEXT,
    INACTIVE
  } spi_state_t;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int unsigned HALF_PERIODS_PER_BYTE = 16;

endpackage

// File: rtl/spi_sck_gen.sv
// -----------------------------------------------------------------------------
// spi_sck_gen
// Half-bit timer and SCK generator for one byte.
// A start pulse launches a sequence of 17 half-periods: one leading low
// half-period (setup time for bit 7), then 8 high/low SCK periods.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   i_start    : one-cycle pulse, begin a byte on the next cycle
//   o_rise     : strobe, sck goes high on the next cycle
//   o_fall     : strobe, sck goes low on the next cycle
//   o_done     : strobe, last half-period of the byte is ending
//   o_sck      : SCK level (idle level is SPI_CPOL)
// -----------------------------------------------------------------------------
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  output logic o_rise,
  output logic o_fall,
  output logic o_done,
  output logic o_sck
);

  localparam logic [7:0] CNT_MAX   = 8'(CLKS_PER_HALF_BIT - 1);
  localparam logic [4:0] LAST_HALF = 5'(HALF_PERIODS_PER_BYTE);

  logic       r_active;
  logic [7:0] r_cnt;
  logic [4:0] r_half;
  logic       r_sck;
  logic       w_tick;

  // Half-period 0 is the leading low phase, so even indices end in a rise,
  // odd indices end in a fall, and index 16 closes the byte.
  assign w_tick = r_active && (r_cnt == CNT_MAX);
  assign o_rise = w_tick && !r_half[0] && (r_half != LAST_HALF);
  assign o_fall = w_tick && r_half[0];
  assign o_done = w_tick && (r_half == LAST_HALF);
  assign o_sck  = r_sck ^ SPI_CPOL;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_cnt    <= 8'd0;
      r_half   <= 5'd0;
      r_sck    <= 1'b0;
    end else begin
      if (i_start) begin
        r_active <= 1'b1;
        r_cnt    <= 8'd0;
        r_half   <= 5'd0;
      end else if (w_tick) begin
        r_cnt  <= 8'd0;
        r_half <= r_half + 5'd1;
        if (r_half == LAST_HALF) begin
          r_active <= 1'b0;
        end
      end else if (r_active) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (o_rise) begin
        r_sck <= 1'b1;
      end else if (o_fall) begin
        r_sck <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Mode-0 SPI master with byte streaming: bytes are accepted over a
// valid/ready handshake and cs_n stays low until a byte marked tx_last
// completes, after which cs_n is held high for CS_INACTIVE_CLKS cycles.
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   tx_byte/tx_valid/
//   tx_last/tx_ready   : transmit handshake, tx_last ends the frame
//   rx_byte/rx_valid   : received byte with a one-cycle valid pulse
//   byte_count         : bytes completed in the current frame (wraps)
//   busy               : FSM is not IDLE
//   sck/cs_n/mosi/miso : SPI bus
// -----------------------------------------------------------------------------
module spi_master
  import spi_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_INACTIVE_CLKS  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic [7:0] byte_count,
  output logic       busy,
  output logic       sck,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [7:0] INACT_MAX = 8'(CS_INACTIVE_CLKS - 1);

  spi_state_t r_state;
  spi_state_t w_nextState;

  logic [7:0] r_txShift;
  logic [7:0] r_rxShift;
  logic [7:0] r_rxByte;
  logic [7:0] r_byteCount;
  logic [7:0] r_inactCnt;
  logic       r_last;
  logic       r_rxValid;

  logic w_accept;
  logic w_rise;
  logic w_fall;
  logic w_done;
  logic w_sck;
  logic w_sample;
  logic w_advance;
  logic w_frameActive;

  spi_sck_gen #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_sck_gen (
    .clk    (clk),
    .reset  (reset),
    .i_start(w_accept),
    .o_rise (w_rise),
    .o_fall (w_fall),
    .o_done (w_done),
    .o_sck  (w_sck)
  );

  assign tx_ready      = (r_state == IDLE) || (r_state == NEXT);
  assign w_accept      = tx_valid && tx_ready;
  assign w_frameActive = (r_state == SETUP) || (r_state == SHIFT) || (r_state == NEXT);

  // Mode 0 samples on the leading edge and shifts on the trailing edge.
  assign w_sample  = (SPI_CPHA == 1'b0) ? w_rise : w_fall;
  assign w_advance = (SPI_CPHA == 1'b0) ? w_fall : w_rise;

  // Gating sck by the frame keeps it at idle level whenever cs_n is high.
  assign cs_n       = !w_frameActive;
  assign sck        = w_frameActive ? w_sck : SPI_CPOL;
  assign mosi       = w_frameActive ? r_txShift[7] : 1'b0;
  assign busy       = (r_state != IDLE);
  assign rx_byte    = r_rxByte;
  assign rx_valid   = r_rxValid;
  assign byte_count = r_byteCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // SETUP ends on the first rise strobe; a byte accepted in NEXT skips SETUP
  // because the sck generator supplies the same leading low half-period.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_nextState = SETUP;
      SETUP:    if (w_rise)   w_nextState = SHIFT;
      SHIFT:    if (w_done)   w_nextState = r_last ? INACTIVE : NEXT;
      NEXT:     if (w_accept) w_nextState = SHIFT;
      INACTIVE: if (r_inactCnt == INACT_MAX) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  // Datapath: the byte and its last flag are latched at acceptance so later
  // changes on the inputs cannot disturb a byte in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_txShift   <= 8'd0;
      r_rxShift   <= 8'd0;
      r_rxByte    <= 8'd0;
      r_byteCount <= 8'd0;
      r_inactCnt  <= 8'd0;
      r_last      <= 1'b0;
      r_rxValid   <= 1'b0;
    end else begin
      r_rxValid <= w_done;

      if (w_accept) begin
        r_txShift <= tx_byte;
        r_last    <= tx_last;
      end else if (w_advance) begin
        r_txShift <= {r_txShift[6:0], 1'b0};
      end

      if (w_sample) begin
        r_rxShift <= {r_rxShift[6:0], miso};
      end

      if (w_done) begin
        r_rxByte    <= r_rxShift;
        r_byteCount <= r_byteCount + 8'd1;
      end else if (w_accept && (r_state == IDLE)) begin
        r_byteCount <= 8'd0;
      end

      if (w_done) begin
        r_inactCnt <= 8'd0;
      end else if (r_state == INACTIVE) begin
        r_inactCnt <= r_inactCnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Directed bench for spi_master with CLKS_PER_HALF_BIT=2, CS_INACTIVE_CLKS=4.
// A mode-0 slave model returns slvData on miso for every byte and records the
// last eight mosi bits seen on sck rising edges in mosiCap.
// -----------------------------------------------------------------------------
module tb_spi_master;

  logic       clk;
  logic       reset;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] byte_count;
  logic       busy;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic       miso;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] slvData    = 8'h00;
  logic [7:0] slvShift   = 8'h00;
  logic [7:0] mosiCap    = 8'h00;
  int         slvBits    = 0;
  logic       slvPrevSck = 1'b0;

  logic [7:0] seenCounts [0:299];
  logic [7:0] seenBytes  [0:299];
  int         seenN;
  int         csHighInFrame;

  spi_master #(
    .CLKS_PER_HALF_BIT(2),
    .CS_INACTIVE_CLKS (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .byte_count(byte_count),
    .busy      (busy),
    .sck       (sck),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode-0 slave: bit 7 is ready before the first rise, next bit after each
  // fall, and the pattern reloads after every eighth fall.
  always @(negedge clk) begin
    slvPrevSck <= sck;
    if (cs_n !== 1'b0) begin
      slvShift <= slvData;
      slvBits  <= 0;
    end else begin
      if (slvPrevSck === 1'b0 && sck === 1'b1) begin
        mosiCap <= {mosiCap[6:0], mosi};
      end
      if (slvPrevSck === 1'b1 && sck === 1'b0) begin
        if (slvBits == 7) begin
          slvShift <= slvData;
          slvBits  <= 0;
        end else begin
          slvShift <= {slvShift[6:0], 1'b0};
          slvBits  <= slvBits + 1;
        end
      end
    end
  end

  assign miso = slvShift[7];

  // Sends one byte from a ready state; lat is the number of cycles from the
  // acceptance edge to the negedge where rx_valid is seen, or -1 on timeout.
  task automatic sendByte(input logic [7:0] b, input logic last, output int lat);
    tx_byte  = b;
    tx_last  = last;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    tx_last  = 1'b0;
    lat = 1;
    while (rx_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (rx_valid !== 1'b1) lat = -1;
  endtask

  // Streams n bytes starting at base with tx_valid held high, tx_last on the
  // final one; records byte_count and rx_byte on every rx_valid pulse.
  task automatic runStream(input int n, input logic [7:0] base);
    int idx;
    bit acc;
    idx           = 0;
    seenN         = 0;
    csHighInFrame = 0;
    tx_byte       = base;
    tx_last       = (n == 1);
    tx_valid      = 1'b1;
    acc           = (tx_ready === 1'b1);
    for (int c = 0; c < n * 40 + 100 && seenN < n; c++) begin
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < n) begin
          tx_byte = base + 8'(idx);
          tx_last = (idx == n - 1);
        end else begin
          tx_valid = 1'b0;
          tx_byte  = 8'h00;
          tx_last  = 1'b0;
        end
      end
      if (rx_valid === 1'b1) begin
        seenCounts[seenN] = byte_count;
        seenBytes[seenN]  = rx_byte;
        seenN++;
      end else if (cs_n !== 1'b0) begin
        csHighInFrame++;
      end
      acc = (tx_valid === 1'b1) && (tx_ready === 1'b1);
    end
    tx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int c = 0; c < 100 && busy !== 1'b0; c++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_byte  = 8'hFF;
    tx_last  = 1'b0;
    repeat (3) @(negedge clk);
    checkCount++;
    if (cs_n !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_cs_n: got %b expected 1", cs_n); end
    checkCount++;
    if (sck !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_sck: got %b expected 0", sck); end
    checkCount++;
    if (mosi !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_mosi: got %b expected 0", mosi); end
    checkCount++;
    if (rx_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checkCount++;
    if (rx_byte !== 8'h00) begin errorCount++; $display("[TB] FAIL reset_rx_byte: got %h expected 00", rx_byte); end
    checkCount++;
    if (byte_count !== 8'h00) begin errorCount++; $display("[TB] FAIL reset_byte_count: got %h expected 00", byte_count); end
    checkCount++;
    if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tx_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    checkCount++;
    if (tx_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_single_byte();
    int k;
    int csHigh;
    int sckBad;
    int rxPulses;
    slvData  = 8'h3C;
    tx_byte  = 8'hA5;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    tx_last  = 1'b0;
    checkCount++;
    if (cs_n !== 1'b0) begin errorCount++; $display("[TB] FAIL single_cs_low: got %b expected 0", cs_n); end
    checkCount++;
    if (mosi !== 1'b1) begin errorCount++; $display("[TB] FAIL single_mosi_bit7: got %b expected 1", mosi); end
    checkCount++;
    if (tx_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL single_ready_low: got %b expected 0", tx_ready); end
    k = 1;
    while (rx_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
      // A stray valid while tx_ready is low must be ignored entirely.
      if (k == 5) begin tx_valid = 1'b1; tx_byte = 8'h00; tx_last = 1'b0; end
      if (k == 6) tx_valid = 1'b0;
    end
    checkCount++;
    if (k != 35) begin errorCount++; $display("[TB] FAIL single_latency: got %0d expected 35", k); end
    checkCount++;
    if (rx_byte !== 8'h3C) begin errorCount++; $display("[TB] FAIL single_rx_byte: got %h expected 3c", rx_byte); end
    checkCount++;
    if (byte_count !== 8'h01) begin errorCount++; $display("[TB] FAIL single_byte_count: got %h expected 01", byte_count); end
    checkCount++;
    if (mosiCap !== 8'hA5) begin errorCount++; $display("[TB] FAIL single_mosi_bits: got %h expected a5", mosiCap); end
    csHigh   = 0;
    sckBad   = 0;
    rxPulses = 0;
    k        = 0;
    while (busy === 1'b1 && k < 100) begin
      if (cs_n === 1'b1) csHigh++;
      if (cs_n === 1'b1 && sck !== 1'b0) sckBad++;
      if (rx_valid === 1'b1) rxPulses++;
      @(negedge clk);
      k++;
    end
    checkCount++;
    if (csHigh != 4) begin errorCount++; $display("[TB] FAIL single_inactive_len: got %0d expected 4", csHigh); end
    checkCount++;
    if (rxPulses != 1) begin errorCount++; $display("[TB] FAIL single_rx_pulse_width: got %0d expected 1", rxPulses); end
    checkCount++;
    if (sckBad != 0) begin errorCount++; $display("[TB] FAIL single_sck_idle: got %0d expected 0", sckBad); end
    checkCount++;
    if (cs_n !== 1'b1 || mosi !== 1'b0) begin
      errorCount++; $display("[TB] FAIL single_idle_pins: got cs_n=%b mosi=%b expected cs_n=1 mosi=0", cs_n, mosi);
    end
  endtask

  task automatic test_burst();
    slvData = 8'h96;
    runStream(3, 8'h01);
    checkCount++;
    if (seenN != 3) begin errorCount++; $display("[TB] FAIL burst_rx_count: got %0d expected 3", seenN); end
    for (int i = 0; i < 3; i++) begin
      checkCount++;
      if (seenCounts[i] !== 8'(i + 1)) begin
        errorCount++; $display("[TB] FAIL burst_byte_count_%0d: got %h expected %h", i, seenCounts[i], 8'(i + 1));
      end
    end
    checkCount++;
    if (csHighInFrame != 0) begin errorCount++; $display("[TB] FAIL burst_cs_held: got %0d high cycles expected 0", csHighInFrame); end
    checkCount++;
    if (seenBytes[2] !== 8'h96) begin errorCount++; $display("[TB] FAIL burst_rx_byte: got %h expected 96", seenBytes[2]); end
    checkCount++;
    if (mosiCap !== 8'h03) begin errorCount++; $display("[TB] FAIL burst_mosi_last: got %h expected 03", mosiCap); end
    waitIdle();
  endtask

  task automatic test_stall();
    int lat;
    int badCs;
    int badSck;
    int badRdy;
    slvData = 8'h5A;
    sendByte(8'h81, 1'b0, lat);
    checkCount++;
    if (lat != 35) begin errorCount++; $display("[TB] FAIL stall_first_latency: got %0d expected 35", lat); end
    badCs  = 0;
    badSck = 0;
    badRdy = 0;
    repeat (50) begin
      @(negedge clk);
      if (cs_n !== 1'b0) badCs++;
      if (sck !== 1'b0) badSck++;
      if (tx_ready !== 1'b1) badRdy++;
    end
    checkCount++;
    if (badCs != 0) begin errorCount++; $display("[TB] FAIL stall_cs_low: got %0d bad cycles expected 0", badCs); end
    checkCount++;
    if (badSck != 0) begin errorCount++; $display("[TB] FAIL stall_sck_low: got %0d bad cycles expected 0", badSck); end
    checkCount++;
    if (badRdy != 0) begin errorCount++; $display("[TB] FAIL stall_ready: got %0d bad cycles expected 0", badRdy); end
    sendByte(8'hC3, 1'b1, lat);
    checkCount++;
    if (lat <= 0) begin errorCount++; $display("[TB] FAIL stall_resume_done: got latency %0d expected completion", lat); end
    checkCount++;
    if (byte_count !== 8'h02) begin errorCount++; $display("[TB] FAIL stall_byte_count: got %h expected 02", byte_count); end
    checkCount++;
    if (rx_byte !== 8'h5A) begin errorCount++; $display("[TB] FAIL stall_rx_byte: got %h expected 5a", rx_byte); end
    checkCount++;
    if (mosiCap !== 8'hC3) begin errorCount++; $display("[TB] FAIL stall_mosi_bits: got %h expected c3", mosiCap); end
    waitIdle();
  endtask

  task automatic test_reset_mid_byte();
    int   rises;
    int   k;
    int   rxPulses;
    logic prevSck;
    slvData  = 8'hE7;
    tx_byte  = 8'hF0;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    prevSck  = sck;
    rises    = 0;
    k        = 0;
    while (rises < 4 && k < 100) begin
      @(negedge clk);
      k++;
      if (prevSck === 1'b0 && sck === 1'b1) rises++;
      prevSck = sck;
    end
    checkCount++;
    if (rises != 4) begin errorCount++; $display("[TB] FAIL midreset_rises: got %0d expected 4", rises); end
    reset = 1'b1;
    @(negedge clk);
    checkCount++;
    if (cs_n !== 1'b1) begin errorCount++; $display("[TB] FAIL midreset_cs_n: got %b expected 1", cs_n); end
    checkCount++;
    if (sck !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset_sck: got %b expected 0", sck); end
    checkCount++;
    if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    reset    = 1'b0;
    rxPulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (rx_valid === 1'b1) rxPulses++;
    end
    checkCount++;
    if (rxPulses != 0) begin errorCount++; $display("[TB] FAIL midreset_no_rx: got %0d pulses expected 0", rxPulses); end
    checkCount++;
    if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset_stays_idle: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int k;
    int inact;
    slvData  = 8'h69;
    tx_byte  = 8'h11;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    k = 0;
    while (rx_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkCount++;
    if (byte_count !== 8'h01) begin errorCount++; $display("[TB] FAIL b2b_first_count: got %h expected 01", byte_count); end
    tx_byte = 8'h22;
    inact   = 0;
    k       = 0;
    // Cycles with cs_n high while still busy form the INACTIVE window.
    while (cs_n !== 1'b0 && k < 50) begin
      if (busy === 1'b1) inact++;
      @(negedge clk);
      k++;
    end
    tx_valid = 1'b0;
    checkCount++;
    if (inact != 4) begin errorCount++; $display("[TB] FAIL b2b_inactive_len: got %0d expected 4", inact); end
    checkCount++;
    if (byte_count !== 8'h00) begin errorCount++; $display("[TB] FAIL b2b_count_restart: got %h expected 00", byte_count); end
    k = 0;
    while (rx_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkCount++;
    if (byte_count !== 8'h01) begin errorCount++; $display("[TB] FAIL b2b_second_count: got %h expected 01", byte_count); end
    checkCount++;
    if (mosiCap !== 8'h22) begin errorCount++; $display("[TB] FAIL b2b_second_mosi: got %h expected 22", mosiCap); end
    waitIdle();
  endtask

  task automatic test_wrap();
    int seqErr;
    slvData = 8'h0F;
    runStream(256, 8'h00);
    checkCount++;
    if (seenN != 256) begin errorCount++; $display("[TB] FAIL wrap_rx_count: got %0d expected 256", seenN); end
    checkCount++;
    if (seenCounts[254] !== 8'hFF) begin errorCount++; $display("[TB] FAIL wrap_count_255: got %h expected ff", seenCounts[254]); end
    checkCount++;
    if (seenCounts[255] !== 8'h00) begin errorCount++; $display("[TB] FAIL wrap_count_256: got %h expected 00", seenCounts[255]); end
    seqErr = 0;
    for (int i = 0; i < 256; i++) begin
      if (seenCounts[i] !== 8'(i + 1)) seqErr++;
    end
    checkCount++;
    if (seqErr != 0) begin errorCount++; $display("[TB] FAIL wrap_count_sequence: got %0d wrong expected 0", seqErr); end
    checkCount++;
    if (csHighInFrame != 0) begin errorCount++; $display("[TB] FAIL wrap_cs_held: got %0d high cycles expected 0", csHighInFrame); end
    waitIdle();
    checkCount++;
    if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL wrap_returns_idle: got %b expected 0", busy); end
  endtask

  initial begin
    reset    = 1'b1;
    tx_byte  = 8'h00;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    $display("[TB] starting spi_master bench");
    test_reset();
    test_single_byte();
    test_burst();
    test_stall();
    test_reset_mid_byte();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
